// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern generator: pattern mode codes,
// the colour-bar table and the default 640x480@60 raster timing.
package vga_pkg;

  localparam logic [1:0] MODE_BAR   = 2'd0;
  localparam logic [1:0] MODE_GRID  = 2'd1;
  localparam logic [1:0] MODE_GRAD  = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // {R,G,B} on/off mask per bar; each set bit expands to a full-scale channel.
  function automatic logic [2:0] bar_rgb_mask(input logic [2:0] idx);
    logic [2:0] mask;
    case (idx)
      3'd0:    mask = 3'b111;
      3'd1:    mask = 3'b110;
      3'd2:    mask = 3'b011;
      3'd3:    mask = 3'b010;
      3'd4:    mask = 3'b101;
      3'd5:    mask = 3'b100;
      3'd6:    mask = 3'b001;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters and the sync/active/first-pixel decodes derived from them.
// Decodes are combinational on the current count; the top registers them.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_active,
  output logic          o_hs_act,
  output logic          o_vs_act,
  output logic          o_frame0,
  output logic          o_line_end,
  output logic          o_frame_end
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (o_line_end) begin
      r_h_cnt <= '0;
      r_v_cnt <= o_frame_end ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  always_comb begin
    o_line_end  = (r_h_cnt == HW'(H_TOTAL - 1));
    o_frame_end = (r_v_cnt == VW'(V_TOTAL - 1));
    o_active    = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
    o_hs_act    = (r_h_cnt >= HW'(HS_FIRST)) && (r_h_cnt <= HW'(HS_LAST));
    o_vs_act    = (r_v_cnt >= VW'(VS_FIRST)) && (r_v_cnt <= VW'(VS_LAST));
    o_frame0    = (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  assign o_h_cnt = r_h_cnt;
  assign o_v_cnt = r_v_cnt;

endmodule

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA test-pattern generator: raster timing plus four selectable
// patterns (bars, grid, gray ramp, solid) with all outputs registered.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int COLOR_W    = 10,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int NUM_BARS   = 8,
  parameter int GRID_PITCH = 32
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic [1:0]                   mode,
  input  logic [3*COLOR_W-1:0]         solid_color,
  output logic [3*COLOR_W-1:0]         data_to_screen,
  output logic                         HSYNC,
  output logic                         FSYNC,
  output logic                         BLANK,
  output logic                         SYNC,
  output logic                         frame_start,
  output logic [$clog2(H_ACTIVE)-1:0]  pix_x,
  output logic [$clog2(V_ACTIVE)-1:0]  pix_y
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int PXW       = $clog2(H_ACTIVE);
  localparam int PYW       = $clog2(V_ACTIVE);
  localparam int BAR_W     = H_ACTIVE / NUM_BARS;
  localparam int BIW       = $clog2(NUM_BARS + 1);
  localparam int BCW       = $clog2(BAR_W + 1);
  localparam int GW        = $clog2(GRID_PITCH);
  localparam int AW        = COLOR_W + 8;
  localparam int GRAD_STEP = (1 << AW) / H_ACTIVE;
  localparam logic [AW:0] STEP_EXT = (AW + 1)'(GRAD_STEP);

  if (NUM_BARS < 1 || NUM_BARS > H_ACTIVE) begin : g_bad_bars
    $error("vga_pattern_gen: NUM_BARS must lie in 1..H_ACTIVE");
  end
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("vga_pattern_gen: every timing field must be non-zero");
  end
  if (GRID_PITCH < 2 || GRID_PITCH > H_ACTIVE) begin : g_bad_pitch
    $error("vga_pattern_gen: GRID_PITCH must lie in 2..H_ACTIVE");
  end

  logic [HW-1:0] w_h_cnt;
  logic [VW-1:0] w_v_cnt;
  logic          w_active, w_hs_act, w_vs_act, w_frame0, w_line_end, w_frame_end;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HW       (HW),       .VW   (VW)
  ) u_timing (
    .i_clk       (sys_clk),
    .i_rst_n     (sys_rst_n),
    .o_h_cnt     (w_h_cnt),
    .o_v_cnt     (w_v_cnt),
    .o_active    (w_active),
    .o_hs_act    (w_hs_act),
    .o_vs_act    (w_vs_act),
    .o_frame0    (w_frame0),
    .o_line_end  (w_line_end),
    .o_frame_end (w_frame_end)
  );

  logic [1:0]           r_mode;
  logic [3*COLOR_W-1:0] r_solid;
  logic [BIW-1:0]       r_bar_idx;
  logic [BCW-1:0]       r_bar_cnt;
  logic [GW-1:0]        r_gx;
  logic [GW-1:0]        r_gy;
  logic [AW-1:0]        r_acc;

  logic [1:0]           w_mode_eff;
  logic [3*COLOR_W-1:0] w_solid_eff;
  logic [AW:0]          w_acc_sum;
  logic [AW-1:0]        w_acc_next;
  logic [2:0]           w_bar_mask;
  logic [COLOR_W-1:0]   w_gray;
  logic                 w_grid_on;
  logic [3*COLOR_W-1:0] w_pix;

  // The frame's first pixel already uses the freshly sampled mode, so a new
  // mode lands cleanly on a frame boundary.
  always_comb begin
    if (w_frame0) begin
      w_mode_eff  = mode;
      w_solid_eff = solid_color;
    end else begin
      w_mode_eff  = r_mode;
      w_solid_eff = r_solid;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mode  <= MODE_BAR;
      r_solid <= '0;
    end else if (w_frame0) begin
      r_mode  <= mode;
      r_solid <= solid_color;
    end
  end

  // Bar index steps every BAR_W pixels; the last bar simply holds to line end.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bar_idx <= '0;
      r_bar_cnt <= '0;
    end else if (w_line_end) begin
      r_bar_idx <= '0;
      r_bar_cnt <= '0;
    end else if (r_bar_idx != BIW'(NUM_BARS - 1)) begin
      if (r_bar_cnt == BCW'(BAR_W - 1)) begin
        r_bar_idx <= r_bar_idx + BIW'(1);
        r_bar_cnt <= '0;
      end else begin
        r_bar_cnt <= r_bar_cnt + BCW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_gx <= '0;
      r_gy <= '0;
    end else if (w_line_end) begin
      r_gx <= '0;
      if (w_frame_end || r_gy == GW'(GRID_PITCH - 1)) begin
        r_gy <= '0;
      end else begin
        r_gy <= r_gy + GW'(1);
      end
    end else if (r_gx == GW'(GRID_PITCH - 1)) begin
      r_gx <= '0;
    end else begin
      r_gx <= r_gx + GW'(1);
    end
  end

  always_comb begin
    w_acc_sum  = {1'b0, r_acc} + STEP_EXT;
    w_acc_next = w_acc_sum[AW] ? '1 : w_acc_sum[AW-1:0];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_acc <= '0;
    end else if (w_line_end) begin
      r_acc <= '0;
    end else if (w_h_cnt < HW'(H_ACTIVE)) begin
      r_acc <= w_acc_next;
    end
  end

  always_comb begin
    w_bar_mask = bar_rgb_mask(3'(r_bar_idx));
    w_gray     = r_acc[AW-1 -: COLOR_W];
    w_grid_on  = (r_gx == '0) || (r_gy == '0) ||
                 (w_h_cnt == HW'(H_ACTIVE - 1)) || (w_v_cnt == VW'(V_ACTIVE - 1));
    w_pix      = '0;
    if (w_active) begin
      case (w_mode_eff)
        MODE_BAR:   w_pix = {{COLOR_W{w_bar_mask[2]}}, {COLOR_W{w_bar_mask[1]}},
                             {COLOR_W{w_bar_mask[0]}}};
        MODE_GRID:  w_pix = w_grid_on ? '1 : '0;
        MODE_GRAD:  w_pix = {w_gray, w_gray, w_gray};
        MODE_SOLID: w_pix = w_solid_eff;
        default:    w_pix = '0;
      endcase
    end else begin
      w_pix = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_to_screen <= '0;
      HSYNC          <= ~HS_POL;
      FSYNC          <= ~VS_POL;
      BLANK          <= 1'b0;
      SYNC           <= 1'b1;
      frame_start    <= 1'b0;
      pix_x          <= '0;
      pix_y          <= '0;
    end else begin
      data_to_screen <= w_pix;
      HSYNC          <= w_hs_act ? HS_POL : ~HS_POL;
      FSYNC          <= w_vs_act ? VS_POL : ~VS_POL;
      BLANK          <= w_active;
      SYNC           <= ~(w_hs_act | w_vs_act);
      frame_start    <= w_frame0;
      pix_x          <= w_active ? PXW'(w_h_cnt) : '0;
      pix_y          <= w_active ? PYW'(w_v_cnt) : '0;
    end
  end

endmodule
